// File: rtl/counter_seq_ctrl_pkg.sv
// ============================================================================
// Module      : counter_seq_ctrl_pkg
// Description : Shared state encoding and mode/direction constants for the
//               counter sequencing controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package counter_seq_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t HOLD = 2'd2;
    localparam state_t DONE = 2'd3;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

endpackage : counter_seq_ctrl_pkg

`default_nettype wire

// File: rtl/counter_seq_prescaler.sv
// ============================================================================
// Module      : counter_seq_prescaler
// Description : Tick generator; one tick every PRESCALE enabled clocks. The
//               phase freezes while disabled and restarts on clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_seq_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int c_CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(PRESCALE - 1);

    logic [c_CW-1:0] r_phase;
    logic            w_wrap;

    assign w_wrap = (r_phase == c_LAST);
    assign o_tick = i_en && w_wrap;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_phase <= '0;
        end else if (i_en) begin
            r_phase <= w_wrap ? '0 : r_phase + 1'b1;
        end
    end

endmodule : counter_seq_prescaler

`default_nettype wire

// File: rtl/counter_seq_ctrl.sv
// ============================================================================
// Module      : counter_seq_ctrl
// Description : Start/stop/pause sequencer for an N-bit up/down counter with
//               terminal-count pulse, one-shot or auto-reload operation.
//               Optional prescaler enabled by COUNTER_SEQ_CTRL_PRESCALE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_seq_ctrl
    import counter_seq_ctrl_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             dir,
    input  logic             mode,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] term_val,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_load;
    logic [WIDTH-1:0] r_term;
    logic             r_dir;
    logic             r_mode;
    logic             r_tc;

    logic             w_start_go;
    logic             w_tick;

    assign w_start_go = start && !stop && ((r_state == IDLE) || (r_state == DONE));

`ifdef COUNTER_SEQ_CTRL_PRESCALE_EN
    logic w_presc_en;
    logic w_presc_clr;

    // Pause has priority over the tick, so the phase must not advance on the
    // cycle that moves RUN into HOLD.
    assign w_presc_en  = (r_state == RUN) && !pause && !stop;
    assign w_presc_clr = stop || w_start_go;

    counter_seq_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_presc_en),
        .i_clr  (w_presc_clr),
        .o_tick (w_tick)
    );
`else
    assign w_tick = (r_state == RUN) && (PRESCALE >= 1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_count <= '0;
            r_load  <= '0;
            r_term  <= '0;
            r_dir   <= 1'b0;
            r_mode  <= 1'b0;
            r_tc    <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            if (stop) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE, DONE: begin
                        if (w_start_go) begin
                            r_load  <= load_val;
                            r_term  <= term_val;
                            r_dir   <= dir;
                            r_mode  <= mode;
                            r_count <= load_val;
                            r_state <= RUN;
                        end
                    end
                    RUN: begin
                        if (pause) begin
                            r_state <= HOLD;
                        end else if (w_tick) begin
                            if (r_count == r_term) begin
                                r_tc <= 1'b1;
                                if (r_mode == MODE_RELOAD) begin
                                    r_count <= r_load;
                                end else begin
                                    r_state <= DONE;
                                end
                            end else if (r_dir == DIR_UP) begin
                                r_count <= r_count + 1'b1;
                            end else begin
                                r_count <= r_count - 1'b1;
                            end
                        end
                    end
                    HOLD: begin
                        if (!pause) begin
                            r_state <= RUN;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign busy  = (r_state == RUN) || (r_state == HOLD);
    assign done  = (r_state == DONE);

endmodule : counter_seq_ctrl

`default_nettype wire
